binary_adder_32_bit_serial: RTL and testbench



---
 rtl/binary_arith_pkg.sv | 24 ++
 rtl/digit_adder.sv | 25 ++
 rtl/binary_adder_32_bit_serial.sv | 141 ++++++++++++++
 tb/tb_binary_adder_32_bit_serial.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/binary_arith_pkg.sv
// Shared definitions for the serial binary arithmetic blocks: FSM state
// encoding, default operand width and the digit-count helper.
package binary_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // Number of DIGIT_W-wide digits in a WIDTH-bit operand; a zero digit width
  // is rejected at elaboration by the user, so return 1 to keep math defined.
  function automatic int unsigned digit_count(input int unsigned width,
                                              input int unsigned digit_w);
    if (digit_w == 0) begin
      return 1;
    end else begin
      return width / digit_w;
    end
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT_W-bit combinational ripple-carry adder with carry-in and carry-out;
// one instance forms the whole datapath of the serial adder.
module digit_adder #(
  parameter int unsigned DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  input  logic               cin_i,
  output logic [DIGIT_W-1:0] sum_o,
  output logic               cout_o
);

  // Ripple the carry through the digit one bit at a time.
  always_comb begin
    logic carry_v;
    carry_v = cin_i;
    sum_o   = '0;
    for (int i = 0; i < int'(DIGIT_W); i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry_v;
      carry_v  = (a_i[i] & b_i[i]) | (carry_v & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry_v;
  end

endmodule

// File: rtl/binary_adder_32_bit_serial.sv
// Serial adder s = a + b + cin, DIGIT_W bits per clock LSB first, with a
// start/ready/done handshake. Define ADDER_OVERFLOW_FLAG_EN to add the ovf port.
module binary_adder_32_bit_serial
  import binary_arith_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef ADDER_OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned      NDIG     = digit_count(WIDTH, DIGIT_W);
  localparam int unsigned      CNT_W    = $clog2(NDIG) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  generate
    if (DIGIT_W == 0 || (WIDTH % DIGIT_W) != 0) begin : g_bad_digit_w
      $error("DIGIT_W must be non-zero and divide WIDTH exactly");
    end
  endgenerate

  state_e             state_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   res_d;
  logic [WIDTH-1:0]   s_q;
  logic               carry_q;
  logic               cout_q;
  logic               ready_q;
  logic               done_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DIGIT_W-1:0] dig_sum_s;
  logic               dig_cout_s;
  logic               last_s;
`ifdef ADDER_OVERFLOW_FLAG_EN
  logic               ovf_q;
  logic               ovf_d;
`endif

  digit_adder #(
    .DIGIT_W (DIGIT_W)
  ) u_digit_adder (
    .a_i    (a_sh_q[DIGIT_W-1:0]),
    .b_i    (b_sh_q[DIGIT_W-1:0]),
    .cin_i  (carry_q),
    .sum_o  (dig_sum_s),
    .cout_o (dig_cout_s)
  );

  // The partial sum fills from the top so the last digit lands in place.
  always_comb begin
    res_d  = (res_q >> DIGIT_W) | (WIDTH'(dig_sum_s) << (WIDTH - DIGIT_W));
    last_s = (cnt_q == LAST_CNT);
  end

`ifdef ADDER_OVERFLOW_FLAG_EN
  // Carry into the MSB is recovered from the MSB sum bit of the final digit.
  always_comb begin
    ovf_d = a_sh_q[DIGIT_W-1] ^ b_sh_q[DIGIT_W-1] ^ dig_sum_s[DIGIT_W-1] ^ dig_cout_s;
  end
`endif

  // Control FSM with datapath registers; all outputs are registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef ADDER_OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            res_q   <= '0;
            carry_q <= cin;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> DIGIT_W;
          b_sh_q  <= b_sh_q >> DIGIT_W;
          res_q   <= res_d;
          carry_q <= dig_cout_s;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_s) begin
            s_q     <= res_d;
            cout_q  <= dig_cout_s;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef ADDER_OVERFLOW_FLAG_EN
            ovf_q   <= ovf_d;
`endif
          end
        end
        default: begin
          ready_q <= 1'b1;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign s     = s_q;
  assign cout  = cout_q;
`ifdef ADDER_OVERFLOW_FLAG_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_binary_adder_32_bit_serial.sv
// Scoreboard bench for binary_adder_32_bit_serial: a DIGIT_W=1 and a DIGIT_W=4
// instance, directed vectors, monitors compare results and latency on done.
module tb_binary_adder_32_bit_serial;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0, start4 = 1'b0;
  logic [31:0] a = 32'd0, b = 32'd0, a4 = 32'd0, b4 = 32'd0;
  logic        cin = 1'b0, cin4 = 1'b0;
  logic        ready, done, cout, ready4, done4, cout4;
  logic [31:0] s, s4;
`ifdef ADDER_OVERFLOW_FLAG_EN
  logic        ovf, ovf4;
`endif

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t q4[$];
  exp_t e_m, e_m4;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  logic done_prev = 1'b0, done4_prev = 1'b0;

  binary_adder_32_bit_serial #(.WIDTH(32), .DIGIT_W(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .cin(cin),
    .ready(ready), .done(done), .s(s), .cout(cout)
`ifdef ADDER_OVERFLOW_FLAG_EN
    , .ovf(ovf)
`endif
  );

  binary_adder_32_bit_serial #(.WIDTH(32), .DIGIT_W(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .ready(ready4), .done(done4), .s(s4), .cout(cout4)
`ifdef ADDER_OVERFLOW_FLAG_EN
    , .ovf(ovf4)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_total++;
    if (act === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic timeout(input string nm);
    n_total++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  // Monitor for the DIGIT_W=1 instance.
  always @(negedge clk) begin
    if (reset_n && done && !done_prev) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'(s), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e_m = q.pop_front();
        chk("sum", 64'(s), 64'(e_m.s));
        chk("cout", 64'(cout), 64'(e_m.cout));
        chk("latency", 64'(cyc - e_m.acc), 64'd32);
`ifdef ADDER_OVERFLOW_FLAG_EN
        chk("ovf", 64'(ovf), 64'(e_m.ovf));
`endif
      end
    end
    done_prev <= done;
  end

  // Monitor for the DIGIT_W=4 instance.
  always @(negedge clk) begin
    if (reset_n && done4 && !done4_prev) begin
      if (q4.size() == 0) begin
        chk("unexpected_done4", 64'(s4), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e_m4 = q4.pop_front();
        chk("sum4", 64'(s4), 64'(e_m4.s));
        chk("cout4", 64'(cout4), 64'(e_m4.cout));
        chk("latency4", 64'(cyc - e_m4.acc), 64'd8);
`ifdef ADDER_OVERFLOW_FLAG_EN
        chk("ovf4", 64'(ovf4), 64'(e_m4.ovf));
`endif
      end
    end
    done4_prev <= done4;
  end

  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                       input logic [31:0] es, input logic ec, input logic eo, input bit track);
    int t = 0;
    @(negedge clk);
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready) timeout("ready_wait");
    a = av; b = bv; cin = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (track) q.push_back('{es, ec, eo, cyc});
  endtask

  task automatic do_op4(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                        input logic [31:0] es, input logic ec, input logic eo);
    int t = 0;
    @(negedge clk);
    while (!ready4 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready4) timeout("ready4_wait");
    a4 = av; b4 = bv; cin4 = cv; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    q4.push_back('{es, ec, eo, cyc});
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!done) timeout("done_wait");
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #2;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    wait_done();
    do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    wait_done();
    do_op(32'h5555_5555, 32'h5555_5555, 1'b0, 32'hAAAA_AAAA, 1'b0, 1'b1, 1'b1);
    wait_done();

    // Start while busy: must be ignored and must not disturb the held result.
    do_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    a = 32'd1; b = 32'd1; start = 1'b1;
    chk("busy_ready", 64'(ready), 64'd0);
    chk("busy_s_held", 64'(s), 64'hAAAA_AAAA);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Start in DONE: done drops on the next cycle, s held until the final edge.
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, 1'b1, 1'b1);
    chk("done_drop", 64'(done), 64'd0);
    chk("run_s_held", 64'(s), 64'h0001_0000);
    wait_done();

    // Reset during RUN aborts asynchronously.
    do_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_s", 64'(s), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_abort_done", 64'(done), 64'd0);

    do_op(32'h1234_5678, 32'h8765_4321, 1'b1, 32'h9999_999A, 1'b0, 1'b0, 1'b1);
    wait_done();
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    wait_done();
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    wait_done();

    do_op4(32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0);
    do_op4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

    begin
      int t = 0;
      while ((q.size() != 0 || q4.size() != 0) && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (q.size() != 0 || q4.size() != 0) timeout("drain");
    end
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
